rs_alu: RTL and testbench
=========================

RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation-station entries (power of two, 2..16).
REQ-002 SHALL have parameter ROB_W, default `ROB_SIZE_WIDTH, width of ROB tags.
REQ-003 SHALL have one clock and synchronous active-high reset; clk_in is the sole clock and rst_in is the sole reset.
REQ-004 clk_in  in  1  clock; all state updates on posedge.
REQ-005 rst_in  in  1  synchronous active-high reset.
REQ-006 rdy_in  in  1  global enable; low freezes all state and outputs.
REQ-007 flush_in  in  1  ROB mispredict clear.
REQ-008 disp_valid  in  1  dispatch request.
REQ-009 disp_op_L1  in  3  ALU major op; disp_op_L2  in  1  sub/sra select.
REQ-010 disp_rob_id  in  ROB_W  destination tag.
REQ-011 disp_vj, disp_vk  in  32 each  operand values; disp_qj, disp_qk  in  ROB_W each  producer tags; disp_j_rdy, disp_k_rdy  in  1 each  operand already valid.
REQ-012 cdb0_valid/cdb0_rob_id/cdb0_value  in  1/ROB_W/32  ALU result broadcast; cdb1_* same widths, LSB result broadcast.
REQ-013 full  out  1  no free entry; combinational from registered state.
REQ-014 alu_valid  out  1  registered; issue strobe to ALU.
REQ-015 alu_opr1, alu_opr2  out  32 each; alu_rob_id  out  ROB_W; alu_op_L1  out  3; alu_op_L2  out  1; all registered.

Function
REQ-016 Entry state: busy, op_L1, op_L2, rob_id, vj, vk, qj, qk, j_rdy, k_rdy.
REQ-017 full SHALL equal 1 iff all RS_SIZE entries busy; disp_valid while full SHALL be ignored (no entry written, no error).
REQ-018 Dispatch: if disp_valid and !full, lowest-index non-busy entry SHALL be written at posedge with busy=1.
REQ-019 Wakeup: each cycle, any busy entry with !j_rdy and qj matching a valid CDB tag SHALL load vj from that CDB and set j_rdy; same for k; cdb0 has priority if both match.
REQ-020 Dispatch bypass: dispatched operand with !disp_x_rdy whose tag matches a valid CDB in the same cycle SHALL be stored ready with the CDB value.
REQ-021 Issue: among busy entries with j_rdy&&k_rdy at the clock edge (pre-update state), lowest index SHALL be selected; at posedge alu_valid=1, operands/tag/op driven from that entry, entry busy cleared.
REQ-022 If no entry eligible, alu_valid SHALL be 0 next cycle; other alu_* outputs hold last value.
REQ-023 Latency: operands ready at dispatch -> alu_valid the cycle after dispatch (1-cycle min RS residency); at most one issue and one dispatch per cycle.
REQ-024 An entry freed by issue SHALL be reusable by dispatch on the following cycle, not the same cycle.
REQ-025 Wakeup during the issue cycle of a different entry SHALL not be lost.
REQ-026 flush_in=1 (with rdy_in=1) SHALL clear all busy bits and alu_valid at posedge; dispatch and wakeup in that cycle discarded; flush dominates everything except rst_in.
REQ-027 rdy_in=0 SHALL hold all entries and outputs unchanged, including alu_valid.

Reset
REQ-028 rst_in=1 SHALL clear all busy bits, alu_valid=0, alu_opr1=alu_opr2=0, alu_rob_id=0, alu_op_L1=0, alu_op_L2=0, full=0; reset dominates rdy_in and flush_in, including mid-operation.

Verification
REQ-029 Dispatch ADD vj=5,vk=7 both ready, rob 3 -> next cycle alu_valid=1, opr1=5, opr2=7, rob_id=3, op_L1=0.
REQ-030 Dispatch with qj=2 not ready; 3 cycles later cdb0 rob 2 value 0x10 -> alu_valid next cycle with opr1=0x10; never earlier.
REQ-031 Dispatch qk=4 not ready same cycle as cdb1 rob 4 value 9 -> entry issues next cycle with opr2=9.
REQ-032 Fill 8 entries all waiting on tag 1 -> full=1; 9th dispatch ignored; cdb0 tag 1 -> entries issue one per cycle in index order, full drops after first issue.
REQ-033 Entries busy, flush_in pulse with simultaneous disp_valid -> all busy=0, alu_valid=0, full=0; no later issue.
REQ-034 rdy_in low 2 cycles with ready entry -> no issue, state held; issues on first rdy_in high cycle.

Source files
------------

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops until both operands are ready,
// snoops the two CDBs for wakeup and issues the lowest-index ready entry each cycle.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module rs_alu #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned ROB_W   = `ROB_SIZE_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             disp_valid,
  input  logic [2:0]       disp_op_L1,
  input  logic             disp_op_L2,
  input  logic [ROB_W-1:0] disp_rob_id,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic             disp_j_rdy,
  input  logic             disp_k_rdy,
  input  logic             cdb0_valid,
  input  logic [ROB_W-1:0] cdb0_rob_id,
  input  logic [31:0]      cdb0_value,
  input  logic             cdb1_valid,
  input  logic [ROB_W-1:0] cdb1_rob_id,
  input  logic [31:0]      cdb1_value,
  output logic             full,
  output logic             alu_valid,
  output logic [31:0]      alu_opr1,
  output logic [31:0]      alu_opr2,
  output logic [ROB_W-1:0] alu_rob_id,
  output logic [2:0]       alu_op_L1,
  output logic             alu_op_L2
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic             busy;
    logic [2:0]       op_l1;
    logic             op_l2;
    logic [ROB_W-1:0] rob_id;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic             j_rdy;
    logic             k_rdy;
  } entry_t;

  entry_t           rs_q [RS_SIZE];
  entry_t           rs_d [RS_SIZE];
  entry_t           disp_e;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             issue_found;
  logic [IDX_W-1:0] issue_idx;

  // Operand capture from the CDBs; cdb0 wins when both carry the same tag.
  function automatic logic [32:0] snoop(input logic rdy, input logic [ROB_W-1:0] q,
                                        input logic [31:0] v);
    snoop = {rdy, v};
    if (!rdy) begin
      if (cdb0_valid && cdb0_rob_id == q)      snoop = {1'b1, cdb0_value};
      else if (cdb1_valid && cdb1_rob_id == q) snoop = {1'b1, cdb1_value};
    end
  endfunction

  // Priority pick of the first free slot and the first ready entry, both from registered state.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!rs_q[i].busy && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (rs_q[i].busy && rs_q[i].j_rdy && rs_q[i].k_rdy && !issue_found) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
    end
  end

  assign full = !free_found;

  always_comb begin
    disp_e        = '0;
    disp_e.busy   = 1'b1;
    disp_e.op_l1  = disp_op_L1;
    disp_e.op_l2  = disp_op_L2;
    disp_e.rob_id = disp_rob_id;
    disp_e.qj     = disp_qj;
    disp_e.qk     = disp_qk;
    {disp_e.j_rdy, disp_e.vj} = snoop(disp_j_rdy, disp_qj, disp_vj);
    {disp_e.k_rdy, disp_e.vk} = snoop(disp_k_rdy, disp_qk, disp_vk);
  end

  // Next entry state: wakeup, then issue release, then dispatch into the free slot.
  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      rs_d[i] = rs_q[i];
      if (rs_q[i].busy) begin
        {rs_d[i].j_rdy, rs_d[i].vj} = snoop(rs_q[i].j_rdy, rs_q[i].qj, rs_q[i].vj);
        {rs_d[i].k_rdy, rs_d[i].vk} = snoop(rs_q[i].k_rdy, rs_q[i].qk, rs_q[i].vk);
      end
      if (issue_found && issue_idx == IDX_W'(i)) rs_d[i].busy = 1'b0;
      if (disp_valid && free_found && free_idx == IDX_W'(i)) rs_d[i] = disp_e;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) rs_q[i] <= '0;
      alu_valid  <= 1'b0;
      alu_opr1   <= '0;
      alu_opr2   <= '0;
      alu_rob_id <= '0;
      alu_op_L1  <= '0;
      alu_op_L2  <= 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int unsigned i = 0; i < RS_SIZE; i++) rs_q[i].busy <= 1'b0;
        alu_valid <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < RS_SIZE; i++) rs_q[i] <= rs_d[i];
        alu_valid <= issue_found;
        if (issue_found) begin
          alu_opr1   <= rs_q[issue_idx].vj;
          alu_opr2   <= rs_q[issue_idx].vk;
          alu_rob_id <= rs_q[issue_idx].rob_id;
          alu_op_L1  <= rs_q[issue_idx].op_l1;
          alu_op_L2  <= rs_q[issue_idx].op_l2;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios followed by random traffic, all checked
// against a behavioural model of the reservation station.
module tb_rs_alu;

  localparam int RS = 8;
  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, flush_in, disp_valid;
  logic [2:0]    disp_op_L1;
  logic          disp_op_L2;
  logic [RW-1:0] disp_rob_id, disp_qj, disp_qk;
  logic [31:0]   disp_vj, disp_vk;
  logic          disp_j_rdy, disp_k_rdy;
  logic          cdb0_valid, cdb1_valid;
  logic [RW-1:0] cdb0_rob_id, cdb1_rob_id;
  logic [31:0]   cdb0_value, cdb1_value;
  logic          full, alu_valid, alu_op_L2;
  logic [31:0]   alu_opr1, alu_opr2;
  logic [RW-1:0] alu_rob_id;
  logic [2:0]    alu_op_L1;

  rs_alu #(.RS_SIZE(RS), .ROB_W(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_op_L1(disp_op_L1), .disp_op_L2(disp_op_L2),
    .disp_rob_id(disp_rob_id), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_j_rdy(disp_j_rdy), .disp_k_rdy(disp_k_rdy),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
    .full(full), .alu_valid(alu_valid), .alu_opr1(alu_opr1), .alu_opr2(alu_opr2),
    .alu_rob_id(alu_rob_id), .alu_op_L1(alu_op_L1), .alu_op_L2(alu_op_L2)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a table of waiting ops plus the last issued op.
  logic          m_busy [RS];
  logic [2:0]    m_l1   [RS];
  logic          m_l2   [RS];
  logic [RW-1:0] m_rob  [RS];
  logic [RW-1:0] m_qj   [RS];
  logic [RW-1:0] m_qk   [RS];
  logic [31:0]   m_vj   [RS];
  logic [31:0]   m_vk   [RS];
  logic          m_jr   [RS];
  logic          m_kr   [RS];
  logic          e_valid, e_l2;
  logic [31:0]   e_opr1, e_opr2;
  logic [RW-1:0] e_rob;
  logic [2:0]    e_l1;

  function automatic bit cdb_hit(input logic [RW-1:0] tag, output logic [31:0] val);
    val = '0;
    if (cdb0_valid && cdb0_rob_id == tag) begin val = cdb0_value; return 1'b1; end
    if (cdb1_valid && cdb1_rob_id == tag) begin val = cdb1_value; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < RS; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    int pick, slot;
    logic [31:0] v;
    if (rst_in) begin
      for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
      e_valid = 1'b0; e_opr1 = '0; e_opr2 = '0; e_rob = '0; e_l1 = '0; e_l2 = 1'b0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
        e_valid = 1'b0;
      end else begin
        pick = -1;
        slot = -1;
        for (int i = 0; i < RS; i++) begin
          if (pick < 0 && m_busy[i] && m_jr[i] && m_kr[i]) pick = i;
          if (slot < 0 && !m_busy[i]) slot = i;
        end
        e_valid = (pick >= 0);
        if (pick >= 0) begin
          e_opr1 = m_vj[pick]; e_opr2 = m_vk[pick]; e_rob = m_rob[pick];
          e_l1 = m_l1[pick]; e_l2 = m_l2[pick];
          m_busy[pick] = 1'b0;
        end
        for (int i = 0; i < RS; i++) begin
          if (m_busy[i] && !m_jr[i] && cdb_hit(m_qj[i], v)) begin m_vj[i] = v; m_jr[i] = 1'b1; end
          if (m_busy[i] && !m_kr[i] && cdb_hit(m_qk[i], v)) begin m_vk[i] = v; m_kr[i] = 1'b1; end
        end
        if (disp_valid && slot >= 0) begin
          m_busy[slot] = 1'b1; m_l1[slot] = disp_op_L1; m_l2[slot] = disp_op_L2;
          m_rob[slot] = disp_rob_id; m_qj[slot] = disp_qj; m_qk[slot] = disp_qk;
          m_vj[slot] = disp_vj; m_vk[slot] = disp_vk;
          m_jr[slot] = disp_j_rdy; m_kr[slot] = disp_k_rdy;
          if (!m_jr[slot] && cdb_hit(m_qj[slot], v)) begin m_vj[slot] = v; m_jr[slot] = 1'b1; end
          if (!m_kr[slot] && cdb_hit(m_qk[slot], v)) begin m_vk[slot] = v; m_kr[slot] = 1'b1; end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare everything.
  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    check("alu_valid", 32'(alu_valid), 32'(e_valid));
    check("alu_opr1", alu_opr1, e_opr1);
    check("alu_opr2", alu_opr2, e_opr2);
    check("alu_rob_id", 32'(alu_rob_id), 32'(e_rob));
    check("alu_op_L1", 32'(alu_op_L1), 32'(e_l1));
    check("alu_op_L2", 32'(alu_op_L2), 32'(e_l2));
    check("full", 32'(full), 32'(m_full()));
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; disp_valid = 1'b0;
    disp_op_L1 = '0; disp_op_L2 = 1'b0; disp_rob_id = '0;
    disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
    disp_j_rdy = 1'b0; disp_k_rdy = 1'b0;
    cdb0_valid = 1'b0; cdb0_rob_id = '0; cdb0_value = '0;
    cdb1_valid = 1'b0; cdb1_rob_id = '0; cdb1_value = '0;
  endtask

  task automatic disp(input logic [2:0] op, input logic [RW-1:0] rob,
                      input logic [31:0] vj, input logic jr, input logic [RW-1:0] qj,
                      input logic [31:0] vk, input logic kr, input logic [RW-1:0] qk);
    disp_valid = 1'b1; disp_op_L1 = op; disp_op_L2 = 1'b0; disp_rob_id = rob;
    disp_vj = vj; disp_j_rdy = jr; disp_qj = qj;
    disp_vk = vk; disp_k_rdy = kr; disp_qk = qk;
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    step(); step();
    check("rst_valid", 32'(alu_valid), 0);
    check("rst_full", 32'(full), 0);

    // ADD with both operands ready issues the cycle after dispatch.
    idle(); disp(3'd0, 4'd3, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0); step();
    check("add_no_early", 32'(alu_valid), 0);
    idle(); step();
    check("add_valid", 32'(alu_valid), 1);
    check("add_opr1", alu_opr1, 32'd5);
    check("add_opr2", alu_opr2, 32'd7);
    check("add_rob", 32'(alu_rob_id), 3);

    // Waiting on tag 2, woken by cdb0.
    idle(); disp(3'd1, 4'd6, 32'h0, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0); step();
    idle(); step(); step();
    check("wait_no_early", 32'(alu_valid), 0);
    cdb0_valid = 1'b1; cdb0_rob_id = 4'd2; cdb0_value = 32'h10; step();
    check("wake_no_early", 32'(alu_valid), 0);
    idle(); step();
    check("wake_valid", 32'(alu_valid), 1);
    check("wake_opr1", alu_opr1, 32'h10);

    // Dispatch-cycle bypass from cdb1.
    idle(); disp(3'd2, 4'd7, 32'd3, 1'b1, 4'd0, 32'h0, 1'b0, 4'd4);
    cdb1_valid = 1'b1; cdb1_rob_id = 4'd4; cdb1_value = 32'd9; step();
    idle(); step();
    check("byp_valid", 32'(alu_valid), 1);
    check("byp_opr2", alu_opr2, 32'd9);

    // Fill all entries on tag 1, overflow dispatch ignored, drain in index order.
    for (int i = 0; i < RS; i++) begin
      idle(); disp(3'd3, RW'(i + 8), 32'h0, 1'b0, 4'd1, 32'(i), 1'b1, 4'd0); step();
    end
    check("fill_full", 32'(full), 1);
    idle(); disp(3'd4, 4'd5, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0); step();
    check("ovf_no_issue", 32'(alu_valid), 0);
    idle(); cdb0_valid = 1'b1; cdb0_rob_id = 4'd1; cdb0_value = 32'hAB; step();
    for (int i = 0; i < RS; i++) begin
      idle(); step();
      check("drain_valid", 32'(alu_valid), 1);
      check("drain_rob", 32'(alu_rob_id), 32'(i + 8));
      if (i == 0) check("drain_full", 32'(full), 0);
    end
    idle(); step();
    check("drain_done", 32'(alu_valid), 0);

    // Flush with a simultaneous dispatch.
    for (int i = 0; i < 3; i++) begin
      idle(); disp(3'd5, RW'(i), 32'h0, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0); step();
    end
    idle(); flush_in = 1'b1; disp(3'd0, 4'd9, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0); step();
    check("flush_full", 32'(full), 0);
    check("flush_valid", 32'(alu_valid), 0);
    idle(); cdb0_valid = 1'b1; cdb0_rob_id = 4'd5; cdb0_value = 32'd1; step();
    for (int i = 0; i < 3; i++) begin
      idle(); step();
      check("flush_no_issue", 32'(alu_valid), 0);
    end

    // Stall with a ready entry.
    idle(); disp(3'd6, 4'd12, 32'd2, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0); step();
    idle(); rdy_in = 1'b0; step(); step();
    check("stall_no_issue", 32'(alu_valid), 0);
    idle(); step();
    check("stall_release", 32'(alu_valid), 1);
    check("stall_rob", 32'(alu_rob_id), 12);

    // Reset in the middle of traffic, with rdy_in low and flush high.
    idle(); disp(3'd1, 4'd2, 32'd4, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0); step();
    idle(); rst_in = 1'b1; rdy_in = 1'b0; flush_in = 1'b1; step();
    check("mid_rst_opr1", alu_opr1, 0);
    idle(); step();
    check("mid_rst_no_issue", 32'(alu_valid), 0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy_in      = ($urandom_range(9) != 0);
      flush_in    = ($urandom_range(49) == 0);
      rst_in      = ($urandom_range(199) == 0);
      disp_valid  = ($urandom_range(1) == 0);
      disp_op_L1  = 3'($urandom());
      disp_op_L2  = 1'($urandom());
      disp_rob_id = RW'($urandom());
      disp_vj     = $urandom();
      disp_vk     = $urandom();
      disp_qj     = RW'($urandom_range(7));
      disp_qk     = RW'($urandom_range(7));
      disp_j_rdy  = ($urandom_range(2) == 0);
      disp_k_rdy  = ($urandom_range(2) == 0);
      cdb0_valid  = ($urandom_range(2) == 0);
      cdb0_rob_id = RW'($urandom_range(7));
      cdb0_value  = $urandom();
      cdb1_valid  = ($urandom_range(2) == 0);
      cdb1_rob_id = RW'($urandom_range(7));
      cdb1_value  = $urandom();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
